uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive side, 8N1/8N2, LSB first, mid-bit sampling.
// Bytes come out with a one-cycle rx_valid pulse. A sampled stop bit of 0
// gives a one-cycle frame_err pulse instead.
module uart_receiver #(
    parameter int DATA_W = 8,
    parameter int COMP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_en,
    input  logic [COMP_W-1:0] comp,
    input  logic [1:0]        stop_sel,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RECEIVE = 2'd2,
        STOP    = 2'd3
    } state_t;

    localparam logic [COMP_W-1:0] COMP_ONE = COMP_W'(1);
    localparam logic [3:0]        LAST_BIT = 4'(DATA_W);

    state_t              state, state_n;
    logic                rx_meta, rx_s;
    logic [COMP_W-1:0]   comp_c, comp_c_n;
    logic [3:0]          bit_c, bit_c_n;
    logic [DATA_W-1:0]   shift_reg, shift_reg_n;
    logic [DATA_W-1:0]   rx_data_n;
    logic                rx_valid_n, frame_err_n;
    logic [COMP_W-1:0]   comp_int, comp_int_n;
    logic [1:0]          stop_sel_int, stop_sel_int_n;
    logic [COMP_W-1:0]   half_last;
    logic [COMP_W-1:0]   bit_last;

    // Start bit is checked half a bit period in; data and stop bits one full period apart.
    assign half_last = (comp_int >> 1) - COMP_ONE;
    assign bit_last  = comp_int - COMP_ONE;
    assign busy      = (state != IDLE);

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register, latched config and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            comp_c       <= '0;
            bit_c        <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            comp_int     <= '0;
            stop_sel_int <= '0;
        end else begin
            state        <= state_n;
            comp_c       <= comp_c_n;
            bit_c        <= bit_c_n;
            shift_reg    <= shift_reg_n;
            rx_data      <= rx_data_n;
            rx_valid     <= rx_valid_n;
            frame_err    <= frame_err_n;
            comp_int     <= comp_int_n;
            stop_sel_int <= stop_sel_int_n;
        end
    end

    // Next-state and datapath decisions; the frame returns to IDLE at mid-stop-bit.
    always_comb begin
        state_n        = state;
        comp_c_n       = comp_c;
        bit_c_n        = bit_c;
        shift_reg_n    = shift_reg;
        rx_data_n      = rx_data;
        rx_valid_n     = 1'b0;
        frame_err_n    = 1'b0;
        comp_int_n     = comp_int;
        stop_sel_int_n = stop_sel_int;

        if (!rec_en) begin
            state_n  = IDLE;
            comp_c_n = '0;
            bit_c_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n        = START;
                        comp_int_n     = comp;
                        stop_sel_int_n = stop_sel;
                        comp_c_n       = '0;
                        bit_c_n        = '0;
                    end
                end
                START: begin
                    if (comp_c == half_last) begin
                        comp_c_n = '0;
                        state_n  = rx_s ? IDLE : RECEIVE;
                    end else begin
                        comp_c_n = comp_c + COMP_ONE;
                    end
                end
                RECEIVE: begin
                    if (comp_c == bit_last) begin
                        shift_reg_n = {rx_s, shift_reg[DATA_W-1:1]};
                        comp_c_n    = '0;
                        if (bit_c + 4'd1 == LAST_BIT) begin
                            bit_c_n = '0;
                            state_n = STOP;
                        end else begin
                            bit_c_n = bit_c + 4'd1;
                        end
                    end else begin
                        comp_c_n = comp_c + COMP_ONE;
                    end
                end
                STOP: begin
                    if (comp_c == bit_last) begin
                        comp_c_n = '0;
                        if (!rx_s) begin
                            frame_err_n = 1'b1;
                            bit_c_n     = '0;
                            state_n     = IDLE;
                        end else if (!stop_sel_int[1] || bit_c == 4'd1) begin
                            rx_data_n  = shift_reg;
                            rx_valid_n = 1'b1;
                            bit_c_n    = '0;
                            state_n    = IDLE;
                        end else begin
                            bit_c_n = 4'd1;
                        end
                    end else begin
                        comp_c_n = comp_c + COMP_ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with hand-computed expected bytes and pulse counts.
module tb_uart_receiver;

    logic        clk;
    logic        reset;
    logic        rec_en;
    logic [15:0] comp;
    logic [1:0]  stop_sel;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int errors;
    int checks;
    int cycle;
    int valid_total;
    int err_total;
    int busy_total;
    logic [7:0] data_log [64];
    int         cycle_log [64];

    uart_receiver #(.DATA_W(8), .COMP_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rec_en    (rec_en),
        .comp      (comp),
        .stop_sel  (stop_sel),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used to measure spacing between received bytes.
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor records every pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (valid_total < 64) begin
                data_log[valid_total]  = rx_data;
                cycle_log[valid_total] = cycle;
            end
            valid_total = valid_total + 1;
        end
        if (frame_err) err_total = err_total + 1;
        if (busy) busy_total = busy_total + 1;
    end

    // Advance one clock and land just after the active edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the line at one level for a number of clocks.
    task automatic drive_bit(input logic b, input int n);
        uart_rx = b;
        step(n);
    endtask

    // Drive a whole frame: start, 8 data bits LSB first, one or two stop bits.
    task automatic apply_stimulus(input logic [7:0] data, input int n,
                                  input logic stop1, input logic stop2, input bit two_stop);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(data[i], n);
        drive_bit(stop1, n);
        if (two_stop) drive_bit(stop2, n);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        rec_en = 1'b1;
        step(5);
    endtask

    task automatic test_nominal();
        int bv, be, bb;
        bv = valid_total; be = err_total; bb = busy_total;
        comp = 16'd16; stop_sel = 2'b00;
        apply_stimulus(8'hA5, 16, 1'b1, 1'b1, 1'b0);
        step(20);
        checks++; if (valid_total - bv !== 1) begin errors++; $display("[TB] FAIL nominal_valid_count got=%0d exp=1", valid_total - bv); end
        checks++; if (data_log[bv] !== 8'hA5) begin errors++; $display("[TB] FAIL nominal_pulse_data got=%h exp=a5", data_log[bv]); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL nominal_rx_data got=%h exp=a5", rx_data); end
        checks++; if (err_total - be !== 0) begin errors++; $display("[TB] FAIL nominal_frame_err got=%0d exp=0", err_total - be); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nominal_busy_after got=%b exp=0", busy); end
        checks++; if (busy_total - bb < 100) begin errors++; $display("[TB] FAIL nominal_busy_during got=%0d exp>=100", busy_total - bb); end
    endtask

    task automatic test_glitch();
        int bv, be, bb;
        bv = valid_total; be = err_total; bb = busy_total;
        comp = 16'd16;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 30);
        checks++; if (busy_total - bb == 0) begin errors++; $display("[TB] FAIL glitch_busy_pulse got=0 exp>0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_after got=%b exp=0", busy); end
        checks++; if (valid_total - bv !== 0) begin errors++; $display("[TB] FAIL glitch_valid got=%0d exp=0", valid_total - bv); end
        checks++; if (err_total - be !== 0) begin errors++; $display("[TB] FAIL glitch_frame_err got=%0d exp=0", err_total - be); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL glitch_rx_data got=%h exp=a5", rx_data); end
    endtask

    task automatic test_framing();
        int bv, be;
        comp = 16'd16;
        bv = valid_total; be = err_total;
        stop_sel = 2'b00;
        apply_stimulus(8'h3C, 16, 1'b0, 1'b1, 1'b0);
        step(40);
        checks++; if (err_total - be !== 1) begin errors++; $display("[TB] FAIL ferr1_count got=%0d exp=1", err_total - be); end
        checks++; if (valid_total - bv !== 0) begin errors++; $display("[TB] FAIL ferr1_valid got=%0d exp=0", valid_total - bv); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL ferr1_rx_data got=%h exp=a5", rx_data); end
        bv = valid_total; be = err_total;
        stop_sel = 2'b10;
        apply_stimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        step(40);
        checks++; if (err_total - be !== 1) begin errors++; $display("[TB] FAIL ferr2_count got=%0d exp=1", err_total - be); end
        checks++; if (valid_total - bv !== 0) begin errors++; $display("[TB] FAIL ferr2_valid got=%0d exp=0", valid_total - bv); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL ferr2_rx_data got=%h exp=a5", rx_data); end
        bv = valid_total; be = err_total;
        apply_stimulus(8'h3C, 16, 1'b1, 1'b1, 1'b1);
        step(20);
        checks++; if (valid_total - bv !== 1 || rx_data !== 8'h3C) begin errors++; $display("[TB] FAIL two_stop_ok got=%0d/%h exp=1/3c", valid_total - bv, rx_data); end
        checks++; if (err_total - be !== 0) begin errors++; $display("[TB] FAIL two_stop_err got=%0d exp=0", err_total - be); end
        stop_sel = 2'b00;
    endtask

    task automatic test_back_to_back();
        int bv;
        bv = valid_total;
        comp = 16'd10; stop_sel = 2'b00;
        apply_stimulus(8'h00, 10, 1'b1, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 10, 1'b1, 1'b1, 1'b0);
        step(20);
        checks++; if (valid_total - bv !== 2) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=2", valid_total - bv); end
        checks++; if (data_log[bv] !== 8'h00) begin errors++; $display("[TB] FAIL b2b_first got=%h exp=00", data_log[bv]); end
        checks++; if (data_log[bv+1] !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second got=%h exp=ff", data_log[bv+1]); end
        checks++; if (cycle_log[bv+1] - cycle_log[bv] !== 100) begin errors++; $display("[TB] FAIL b2b_spacing got=%0d exp=100", cycle_log[bv+1] - cycle_log[bv]); end
    endtask

    task automatic test_abort();
        int bv, be;
        logic [7:0] d;
        comp = 16'd16;
        bv = valid_total; be = err_total;
        d = 8'h81;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        drive_bit(d[4], 6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_rx_data got=%h exp=00", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_pulses got=%b%b exp=00", rx_valid, frame_err); end
        uart_rx = 1'b1;
        step(40);
        checks++; if (valid_total - bv !== 0 || err_total - be !== 0) begin errors++; $display("[TB] FAIL abort_no_pulse got=%0d/%0d exp=0/0", valid_total - bv, err_total - be); end
        d = 8'h55;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
        rec_en = 1'b0;
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rec_en_drop_busy got=%b exp=0", busy); end
        uart_rx = 1'b1;
        step(4);
        rec_en = 1'b1;
        step(10);
        checks++; if (valid_total - bv !== 0 || rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rec_en_drop_hold got=%0d/%h exp=0/00", valid_total - bv, rx_data); end
        apply_stimulus(8'h55, 16, 1'b1, 1'b1, 1'b0);
        step(20);
        checks++; if (valid_total - bv !== 1) begin errors++; $display("[TB] FAIL after_abort_count got=%0d exp=1", valid_total - bv); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("[TB] FAIL after_abort_data got=%h exp=55", rx_data); end
    endtask

    task automatic test_config_latch();
        int bv;
        logic [7:0] d;
        bv = valid_total;
        comp = 16'd16;
        d = 8'h96;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        comp = 16'd8;
        for (int i = 4; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(1'b1, 16);
        step(10);
        checks++; if (valid_total - bv !== 1 || data_log[bv] !== 8'h96) begin errors++; $display("[TB] FAIL latch_frame1 got=%0d/%h exp=1/96", valid_total - bv, data_log[bv]); end
        apply_stimulus(8'h69, 8, 1'b1, 1'b1, 1'b0);
        step(10);
        checks++; if (valid_total - bv !== 2) begin errors++; $display("[TB] FAIL latch_count got=%0d exp=2", valid_total - bv); end
        checks++; if (rx_data !== 8'h69) begin errors++; $display("[TB] FAIL latch_frame2 got=%h exp=69", rx_data); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        errors = 0; checks = 0; cycle = 0;
        valid_total = 0; err_total = 0; busy_total = 0;
        reset = 1'b1; rec_en = 1'b0; comp = 16'd16; stop_sel = 2'b00; uart_rx = 1'b1;
        step(1);
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_abort();
        test_config_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
